// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter that shares one fpmul unit among NREQ requesters, one operation at a time.
// Optional: define FPMUL_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles with a NaN/RespErr response.
module fpmul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NREQ-1:0]      Req,
  input  logic [32*NREQ-1:0]   ReqA,
  input  logic [32*NREQ-1:0]   ReqB,
  output logic [NREQ-1:0]      Ack,
  output logic [31:0]          RespP,
  output logic [5:0]           RespFlags,
  output logic [IDW-1:0]       RespId,
  output logic                 RespErr,
  output logic                 Busy,
  output logic                 MulStart,
  output logic [31:0]          MulA,
  output logic [31:0]          MulB,
  input  logic                 MulDone,
  input  logic [31:0]          MulP,
  input  logic [5:0]           MulFlags
);

  if (NREQ < 2 || NREQ > 16 || IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_cfg_check
    $error("fpmul_arbiter: unsupported NREQ/IDW/TIMEOUT combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [31:0]    mul_a_q, mul_a_d;
  logic [31:0]    mul_b_q, mul_b_d;
  logic [31:0]    resp_p_q, resp_p_d;
  logic [5:0]     resp_flags_q, resp_flags_d;

  logic [31:0]    req_a [NREQ];
  logic [31:0]    req_b [NREQ];
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] scan_id;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_a[g] = ReqA[32*g +: 32];
    assign req_b[g] = ReqB[32*g +: 32];
  end

  // First requesting index after the last served one, wrapping modulo NREQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    scan_id = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan_id = IDW'((32'(ptr_q) + i) % NREQ);
      if (!gnt_vld && Req[scan_id]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan_id;
      end
    end
  end

`ifdef FPMUL_ARB_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            resp_err_q, resp_err_d;
  assign RespErr = resp_err_q;
`else
  assign RespErr = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    resp_id_d    = resp_id_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    resp_p_d     = resp_p_q;
    resp_flags_d = resp_flags_q;
`ifdef FPMUL_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = resp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          id_d    = gnt_id;
          mul_a_d = req_a[gnt_id];
          mul_b_d = req_b[gnt_id];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef FPMUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (MulDone) begin
          resp_p_d     = MulP;
          resp_flags_d = MulFlags;
          resp_id_d    = id_q;
          state_d      = RESP;
`ifdef FPMUL_ARB_TIMEOUT_EN
          resp_err_d   = 1'b0;
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          // TIMEOUT-th WAIT cycle without Done: report a quiet NaN.
          resp_p_d     = 32'h7FC0_0000;
          resp_flags_d = 6'b001000;
          resp_id_d    = id_q;
          resp_err_d   = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        ptr_d   = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      ptr_q        <= IDW'(NREQ - 1);
      id_q         <= '0;
      resp_id_q    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      resp_p_q     <= '0;
      resp_flags_q <= '0;
`ifdef FPMUL_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      resp_id_q    <= resp_id_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      resp_p_q     <= resp_p_d;
      resp_flags_q <= resp_flags_d;
`ifdef FPMUL_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign Busy      = (state_q != IDLE);
  assign MulStart  = (state_q == ISSUE);
  assign MulA      = mul_a_q;
  assign MulB      = mul_b_q;
  assign Ack       = (state_q == RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << id_q) : '0;
  assign RespP     = resp_p_q;
  assign RespFlags = resp_flags_q;
  assign RespId    = resp_id_q;

endmodule
